// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencing controller.
//   - RISC-V branch funct3 condition codes
//   - controller FSM state encoding
//   - default flush length and flush counter width
//   - latched branch request record
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLUSH_CYCLES_DEF = 2;
  // Wide enough for the largest legal flush length (15).
  localparam int FCNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
  } br_req_t;

endpackage

// File: rtl/branch_seq_ctrl_if.sv
// Request / resolution bus of the branch sequencing controller.
//   master : issue side (drives the request, observes resolution)
//   slave  : the controller
interface branch_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        resp_valid;
  logic        taken;
  logic        illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        flush;

  modport master (
    output req_valid, op1, op2, funct3, pc, imm,
    input  req_ready, resp_valid, taken, illegal,
           redirect_valid, redirect_pc, misalign, flush
  );

  modport slave (
    input  req_valid, op1, op2, funct3, pc, imm,
    output req_ready, resp_valid, taken, illegal,
           redirect_valid, redirect_pc, misalign, flush
  );
endinterface

// File: rtl/branch_comp.sv
// Branch condition comparator (purely combinational).
//   op1, op2 : operands
//   funct3   : condition code
//   taken    : condition holds (never set for an illegal code)
//   illegal  : funct3 is 010 or 011
module branch_comp
  import branch_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [2:0]  funct3,
  output logic        taken,
  output logic        illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (op1 == op2);
      F3_BNE:  taken = (op1 != op2);
      F3_BLT:  taken = ($signed(op1) <  $signed(op2));
      F3_BGE:  taken = ($signed(op1) >= $signed(op2));
      F3_BLTU: taken = (op1 <  op2);
      F3_BGEU: taken = (op1 >= op2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencing controller.
// Accepts one branch in IDLE, resolves it one cycle later in EVAL, and on a
// taken, word-aligned target issues a fetch redirect and holds flush for
// FLUSH_CYCLES cycles. Keeps saturating counts of resolved and taken branches.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : request handshake, resolution and redirect outputs
//   br_cnt, taken_cnt   : saturating statistics counters
module branch_seq_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_seq_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  br_req_t           req_q, req_d;
  logic [31:0]       rpc_q, rpc_d;
  logic [CNT_W-1:0]  br_q, br_d, tk_q, tk_d;
  logic [31:0]       target;
  logic              cmp_taken, cmp_illegal;

  branch_comp u_comp (
    .op1     (req_q.op1),
    .op2     (req_q.op2),
    .funct3  (req_q.funct3),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // 32-bit add: wrap-around is intentional and silent.
  assign target = req_q.pc + req_q.imm;

  always_comb begin
    state_d            = state_q;
    fcnt_d             = fcnt_q;
    req_d              = req_q;
    rpc_d              = rpc_q;
    br_d               = br_q;
    tk_d               = tk_q;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.taken          = 1'b0;
    bus.illegal        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = rpc_q;
    bus.misalign       = 1'b0;
    bus.flush          = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d   = '{op1: bus.op1, op2: bus.op2, funct3: bus.funct3,
                      pc: bus.pc, imm: bus.imm};
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        bus.resp_valid = 1'b1;
        bus.taken      = cmp_taken;
        bus.illegal    = cmp_illegal;
        state_d        = S_IDLE;
        if (br_q != '1) br_d = br_q + CNT_W'(1);
        if (cmp_taken) begin
          if (target[1:0] == 2'b00) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = target;
            rpc_d              = target;
            fcnt_d             = FCNT_W'(FLUSH_CYCLES);
            state_d            = S_FLUSH;
            if (tk_q != '1) tk_d = tk_q + CNT_W'(1);
          end else begin
            // Misaligned target: report only, the pipeline is not disturbed.
            bus.misalign = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        bus.flush = 1'b1;
        fcnt_d    = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      req_q   <= '0;
      rpc_q   <= '0;
      br_q    <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      req_q   <= req_d;
      rpc_q   <= rpc_d;
      br_q    <= br_d;
      tk_q    <= tk_d;
    end
  end

  assign br_cnt    = br_q;
  assign taken_cnt = tk_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: a scoreboard of expected
// resolutions (pushed on issue, popped when resp_valid fires) plus inline
// checks of handshake, flush timing, counters and reset behaviour.
module tb_branch_seq_ctrl;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_seq_ctrl_if bif();
  branch_seq_ctrl_if bif4();

  logic [15:0] br_cnt, taken_cnt;
  logic [3:0]  br_cnt4, taken_cnt4;

  branch_seq_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt));

  branch_seq_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4.slave),
    .br_cnt(br_cnt4), .taken_cnt(taken_cnt4));

  assign bif4.req_valid = bif.req_valid;
  assign bif4.op1       = bif.op1;
  assign bif4.op2       = bif.op2;
  assign bif4.funct3    = bif.funct3;
  assign bif4.pc        = bif.pc;
  assign bif4.imm       = bif.imm;

  typedef struct {
    logic        taken;
    logic        illegal;
    logic        redir;
    logic        mis;
    logic [31:0] tgt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          exp_br = 0;
  int          exp_tk = 0;
  logic [31:0] last_rpc = 32'h0;

  function automatic logic model_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bif.resp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got resp_valid=1 want no response");
      end else begin
        e = exp_q.pop_front();
        if ({bif.taken, bif.illegal, bif.redirect_valid, bif.misalign, bif.flush} !==
            {e.taken, e.illegal, e.redir, e.mis, 1'b0}) begin
          bad++;
          $display("FAIL resp_flags: got taken/illegal/redir/misalign/flush=%b%b%b%b%b want %b%b%b%b0",
                   bif.taken, bif.illegal, bif.redirect_valid, bif.misalign, bif.flush,
                   e.taken, e.illegal, e.redir, e.mis);
        end
        total++;
        if (bif.redirect_pc !== (e.redir ? e.tgt : last_rpc)) begin
          bad++;
          $display("FAIL redirect_pc: got %h want %h", bif.redirect_pc, e.redir ? e.tgt : last_rpc);
        end
        if (e.redir) last_rpc = e.tgt;
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, output int waited);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (bif.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bif.req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles want 1", bif.req_ready, n);
    end
    bif.req_valid = 1'b1;
    bif.funct3 = f; bif.op1 = a; bif.op2 = b; bif.pc = p; bif.imm = i;
    e.taken   = model_taken(f, a, b);
    e.illegal = (f == 3'b010) || (f == 3'b011);
    e.tgt     = p + i;
    e.redir   = e.taken && (e.tgt[1:0] == 2'b00);
    e.mis     = e.taken && !e.redir;
    exp_q.push_back(e);
    exp_br++;
    if (e.redir) exp_tk++;
    @(negedge clk);
    bif.req_valid = 1'b0;
    waited = n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.req_valid = 1'b0;
    bif.op1 = '0; bif.op2 = '0; bif.funct3 = '0; bif.pc = '0; bif.imm = '0;
    #12;
    total++;
    if ({bif.req_ready, bif.resp_valid, bif.flush, bif.redirect_valid, bif.misalign} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got ready/resp/flush/redir/mis=%b want 10000",
               {bif.req_ready, bif.resp_valid, bif.flush, bif.redirect_valid, bif.misalign});
    end
    total++;
    if (bif.redirect_pc !== 32'h0) begin
      bad++; $display("FAIL reset_rpc: got %h want 00000000", bif.redirect_pc);
    end
    total++;
    if (br_cnt !== 16'h0 || taken_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_cnt: got br=%0d tk=%0d want 0 0", br_cnt, taken_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_taken_flush();
    int   w;
    logic [2:0] fl, rd;
    issue(F3_BEQ, 32'h1234, 32'h1234, 32'h100, 32'h20, w);
    total++;
    if (bif.req_ready !== 1'b0 || bif.flush !== 1'b0) begin
      bad++; $display("FAIL eval_ready_flush: got ready=%b flush=%b want 0 0", bif.req_ready, bif.flush);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      fl[k] = bif.flush;
      rd[k] = bif.req_ready;
    end
    total++;
    if (fl !== 3'b011 || rd !== 3'b100) begin
      bad++; $display("FAIL flush_window: got flush=%b ready=%b want 011 100 (lsb first cycle)", fl, rd);
    end
    total++;
    if (br_cnt !== exp_br[15:0] || taken_cnt !== exp_tk[15:0]) begin
      bad++; $display("FAIL cnt_taken: got br=%0d tk=%0d want %0d %0d", br_cnt, taken_cnt, exp_br, exp_tk);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    issue(F3_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, w);
    total++;
    if (bif.flush !== 1'b0 || bif.redirect_valid !== 1'b0) begin
      bad++; $display("FAIL nt_no_flush: got flush=%b redir=%b want 0 0", bif.flush, bif.redirect_valid);
    end
    issue(F3_BGE, 32'h5, 32'h7, 32'h340, 32'h8, w);
    total++;
    if (w !== 0) begin
      bad++; $display("FAIL b2b_accept: got %0d extra wait cycles want 0", w);
    end
  endtask

  task automatic test_wrap();
    int w;
    issue(F3_BLT, -32'sd10, -32'sd5, 32'hFFFF_FFF0, 32'h20, w);
  endtask

  task automatic test_misalign();
    int w;
    int prev_tk;
    prev_tk = exp_tk;
    issue(F3_BNE, 32'h1, 32'h2, 32'h200, 32'h2, w);
    @(negedge clk);
    total++;
    if (bif.flush !== 1'b0 || bif.req_ready !== 1'b1) begin
      bad++; $display("FAIL misalign_idle: got flush=%b ready=%b want 0 1", bif.flush, bif.req_ready);
    end
    total++;
    if (taken_cnt !== prev_tk[15:0] || br_cnt !== exp_br[15:0]) begin
      bad++; $display("FAIL misalign_cnt: got br=%0d tk=%0d want %0d %0d", br_cnt, taken_cnt, exp_br, prev_tk);
    end
  endtask

  task automatic test_random();
    int w;
    logic [2:0]  codes [8];
    logic [31:0] a, b, p, i;
    codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      p = $urandom & 32'hFFFF_FFFC;
      i = $urandom & 32'hFFFF_FFFE;
      issue(codes[$urandom_range(0, 7)], a, b, p, i, w);
    end
    repeat (4) @(negedge clk);
    total++;
    if (br_cnt !== exp_br[15:0] || taken_cnt !== exp_tk[15:0]) begin
      bad++; $display("FAIL random_cnt: got br=%0d tk=%0d want %0d %0d", br_cnt, taken_cnt, exp_br, exp_tk);
    end
  endtask

  task automatic test_illegal_reset();
    int w;
    issue(3'b010, 32'h5, 32'h5, 32'h500, 32'h10, w);
    issue(3'b011, 32'h5, 32'h6, 32'h510, 32'h10, w);
    issue(F3_BEQ, 32'h7, 32'h7, 32'h400, 32'h10, w);
    @(negedge clk);
    total++;
    if (bif.flush !== 1'b1) begin
      bad++; $display("FAIL pre_reset_flush: got %b want 1", bif.flush);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bif.flush !== 1'b0 || bif.req_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset: got flush=%b ready=%b want 0 1", bif.flush, bif.req_ready);
    end
    total++;
    if (br_cnt !== 16'h0 || taken_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_clear_cnt: got br=%0d tk=%0d want 0 0", br_cnt, taken_cnt);
    end
    exp_br = 0; exp_tk = 0; last_rpc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({bif.resp_valid, bif.flush, bif.redirect_valid, bif.req_ready} !== 4'b0001) begin
        bad++; $display("FAIL post_reset_quiet: got resp/flush/redir/ready=%b want 0001",
                        {bif.resp_valid, bif.flush, bif.redirect_valid, bif.req_ready});
      end
    end
  endtask

  task automatic test_reset_in_eval();
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.funct3 = F3_BEQ; bif.op1 = 32'h9; bif.op2 = 32'h9; bif.pc = 32'h600; bif.imm = 32'h40;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bif.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({bif.resp_valid, bif.flush, bif.redirect_valid} !== 3'b000) begin
        bad++; $display("FAIL eval_abort: got resp/flush/redir=%b want 000",
                        {bif.resp_valid, bif.flush, bif.redirect_valid});
      end
    end
    total++;
    if (br_cnt !== 16'h0 || bif.redirect_pc !== 32'h0) begin
      bad++; $display("FAIL eval_abort_state: got br=%0d rpc=%h want 0 00000000", br_cnt, bif.redirect_pc);
    end
  endtask

  task automatic test_saturate();
    int w;
    for (int k = 0; k < 17; k++) begin
      issue(F3_BEQ, 32'h1, 32'h1, 32'h1000 + 32'(k) * 32'h10, 32'h8, w);
      if (k == 13) begin
        @(negedge clk);
        total++;
        if (taken_cnt4 !== 4'hE || br_cnt4 !== 4'hE) begin
          bad++; $display("FAIL sat_pre: got br4=%h tk4=%h want e e", br_cnt4, taken_cnt4);
        end
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if (taken_cnt4 !== 4'hF || br_cnt4 !== 4'hF) begin
      bad++; $display("FAIL sat_hold: got br4=%h tk4=%h want f f", br_cnt4, taken_cnt4);
    end
    total++;
    if (taken_cnt !== 16'd17 || br_cnt !== 16'd17) begin
      bad++; $display("FAIL sat_wide: got br=%0d tk=%0d want 17 17", br_cnt, taken_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_taken_flush();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_random();
    test_illegal_reset();
    test_reset_in_eval();
    test_saturate();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_seq_ctrl.md
BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, 2, number of cycles flush is held after a taken branch; legal range 1..15.
REQ-002 Parameter CNT_W, 16, width of the branch and taken statistics counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 req_valid  input  1  branch request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 op1, op2  input  32 each  rs1/rs2 operand values.
REQ-008 funct3  input  3  branch condition code: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-009 pc, imm  input  32 each  branch instruction PC and sign-extended B-immediate.
REQ-010 resp_valid  output  1  one-cycle pulse; branch resolved.
REQ-011 taken  output  1  branch outcome, meaningful only while resp_valid=1.
REQ-012 illegal  output  1  funct3 was 010 or 011; meaningful only while resp_valid=1.
REQ-013 redirect_valid, redirect_pc  output  1, 32  fetch redirect pulse and target.
REQ-014 misalign  output  1  one-cycle pulse; taken target not word-aligned.
REQ-015 flush  output  1  kill younger pipeline instructions.
REQ-016 br_cnt, taken_cnt  output  CNT_W each  saturating counts of resolved and taken branches.

Function
REQ-017 FSM states IDLE, EVAL, FLUSH; state reset value is IDLE.
REQ-018 IDLE: req_ready=1; a request is accepted when req_valid && req_ready; op1, op2, funct3, pc and imm are latched; next state EVAL.
REQ-019 EVAL and FLUSH: req_ready=0; req_valid is ignored and no input is latched.
REQ-020 EVAL: outcome is computed combinationally from the latched operands only, with BLT/BGE signed and BLTU/BGEU unsigned; resp_valid=1 for exactly this cycle, so latency is one cycle after acceptance.
REQ-021 Target = latched pc + latched imm, modulo 2^32; wrap-around is silent.
REQ-022 EVAL, taken, target[1:0]==00: redirect_valid=1 and redirect_pc=target in the same cycle as resp_valid; the flush counter is loaded with FLUSH_CYCLES; next state FLUSH.
REQ-023 EVAL, taken, target[1:0]!=00: misalign=1, redirect_valid=0, no flush; next state IDLE.
REQ-024 EVAL, not taken (including illegal funct3, which is never taken): redirect_valid=0; next state IDLE.
REQ-025 FLUSH: flush=1; the counter decrements each cycle; the state leaves to IDLE in the cycle the counter equals 1, so flush stays high for exactly FLUSH_CYCLES cycles.
REQ-026 redirect_pc holds its last value when redirect_valid=0.
REQ-027 In EVAL, br_cnt increments by 1 and taken_cnt increments by 1 when taken and not misaligned; both saturate at all-ones with no wrap.
REQ-028 Sustained not-taken throughput is one branch per 2 cycles; sustained taken throughput is one per 2+FLUSH_CYCLES cycles.

Reset
REQ-029 rst_n low forces state IDLE, flush counter 0, latched operands 0, redirect_pc 0, br_cnt 0 and taken_cnt 0 asynchronously; all pulse outputs go to 0 and req_ready goes to 1.
REQ-030 Reset asserted in EVAL or FLUSH aborts the operation; no resp_valid, redirect or flush is produced after rst_n rises.

Structure
REQ-031 Package branch_pkg holds the funct3 codes, the FSM state encoding and the FLUSH_CYCLES default.
REQ-032 The existing branch_comp is instantiated as the single sub-module, fed from the latched op1, op2 and funct3; the controller adds no comparison logic of its own.

Verification
REQ-033 BEQ, op1=op2=32'h1234, pc=32'h100, imm=32'h20 -> one cycle after acceptance, resp_valid=1, taken=1, redirect_pc=32'h120; flush=1 for 2 cycles; req_ready=0 for 3 cycles.
REQ-034 BLTU, op1=32'hFFFFFFFF, op2=1 -> taken=0, no redirect, no flush; a back-to-back request is accepted 2 cycles after the first.
REQ-035 BLT, op1=-10, op2=-5, pc=32'hFFFFFFF0, imm=32'h20 -> taken=1, redirect_pc=32'h00000010 (wrap-around).
REQ-036 BNE taken, imm=32'h2 -> misalign=1, redirect_valid=0, flush=0, taken_cnt unchanged, br_cnt +1.
REQ-037 funct3=010 -> resp_valid=1, illegal=1, taken=0; with rst_n pulsed low during FLUSH -> flush=0 immediately, then req_ready=1 and both counters read 0.
REQ-038 CNT_W=4, 17 taken branches -> taken_cnt and br_cnt hold at 4'hF.
